// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p: round-robin arbiter sharing one 32-bit SRAM controller between two requesters.
// Latency: strobe one cycle after capture; requester ack one cycle after controller ACK.
// Backpressure: one transaction in flight; the losing requester holds req until it is served.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-low reset
//   i_mX_req/wren/addr/     requester X (0 = instruction fetch, 1 = load/store) request level
//   wdata/bmask             and payload; held until o_mX_ack
//   o_mX_rdata/ack/err      one-cycle completion pulse, read data (held until next ack), timeout flag
//   o_ADDR/WDATA/BMASK      controller payload, driven from the capture registers
//   o_WREN/o_RDEN           single-cycle controller strobes
//   i_RDATA/i_ACK           controller response
//   o_busy/o_grant          not-IDLE indicator, one-hot owner of the current transaction
module sram_arbiter_2p #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [17:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_bmask,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [17:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_bmask,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK,
    output logic        o_busy,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last WAIT cycle index before the transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic        rr;        // 0: port 0 preferred on a tie, 1: port 1 preferred
    logic        owner;     // port that owns the captured transaction
    logic        wren_q;
    logic        err_q;
    logic [17:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic any_req;
    logic pick;
    logic timed_out;

    assign any_req   = i_m0_req | i_m1_req;
    // Tie goes to the rr port; otherwise the only requester wins.
    assign pick      = (i_m0_req & i_m1_req) ? rr : i_m1_req;
    assign timed_out = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (i_ACK || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers, watchdog counter and per-port response data
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt      <= '0;
            rr       <= 1'b0;
            owner    <= 1'b0;
            wren_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            bmask_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= pick;
                        rr      <= ~pick;
                        wren_q  <= pick ? i_m1_wren  : i_m0_wren;
                        addr_q  <= pick ? i_m1_addr  : i_m0_addr;
                        wdata_q <= pick ? i_m1_wdata : i_m0_wdata;
                        bmask_q <= pick ? i_m1_bmask : i_m0_bmask;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (i_ACK) begin
                        err_q <= 1'b0;
                        // Writes leave the owner's last read data untouched.
                        if (!wren_q) begin
                            if (owner) rdata1_q <= i_RDATA;
                            else       rdata0_q <= i_RDATA;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        if (owner) rdata1_q <= '0;
                        else       rdata0_q <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_WREN   = 1'b0;
        o_RDEN   = 1'b0;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_busy   = (state != IDLE);
        o_grant  = 2'b00;
        unique case (state)
            ISSUE: begin
                o_WREN = wren_q;
                o_RDEN = ~wren_q;
            end
            RESP: begin
                o_m0_ack = ~owner;
                o_m1_ack = owner;
            end
            default: ;
        endcase
        if (state != IDLE) begin
            o_grant = owner ? 2'b10 : 2'b01;
        end
        o_m0_err = o_m0_ack & err_q;
        o_m1_err = o_m1_ack & err_q;
    end

    assign o_ADDR     = addr_q;
    assign o_WDATA    = wdata_q;
    assign o_BMASK    = bmask_q;
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb_sram_arbiter_2p: checks sram_arbiter_2p against a latency-accurate controller model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req until their ack.
module tb_sram_arbiter_2p;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        m0_req, m0_wren, m1_req, m1_wren;
    logic [17:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_bmask, m1_bmask;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [17:0] o_ADDR;
    logic [31:0] o_WDATA;
    logic [3:0]  o_BMASK;
    logic        o_WREN, o_RDEN;
    logic [31:0] i_RDATA;
    logic        i_ACK;
    logic        o_busy;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    sram_arbiter_2p #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
        .o_m0_rdata(o_m0_rdata), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
        .o_m1_rdata(o_m1_rdata), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_ADDR(o_ADDR), .o_WDATA(o_WDATA), .o_BMASK(o_BMASK),
        .o_WREN(o_WREN), .o_RDEN(o_RDEN),
        .i_RDATA(i_RDATA), .i_ACK(i_ACK),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    typedef struct {
        int          port;
        logic        wren;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        scramble;   // change payload mid-WAIT
        int          lat;        // expected ack cycle counted from capture
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          ack_log[$];
    logic [31:0] last_rd [2];
    logic        ctr_mute  = 1'b0;
    logic        stray_tgl = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Controller read data as a function of the address it was given.
    function automatic logic [31:0] pat(input logic [17:0] a);
        if (a == 18'h00010) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hA5C3, 14'h0, a[17:16]};
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? o_m0_ack : o_m1_ack;
    endfunction

    function automatic logic [1:0] gnt(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_payload(input int p, input logic rq, input logic wr,
                               input logic [17:0] a, input logic [31:0] wd, input logic [3:0] bm);
        if (p == 0) begin
            m0_req = rq; m0_wren = wr; m0_addr = a; m0_wdata = wd; m0_bmask = bm;
        end else begin
            m1_req = rq; m1_wren = wr; m1_addr = a; m1_wdata = wd; m1_bmask = bm;
        end
    endtask

    task automatic push_exp(input int p, input exp_t e);
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Controller model: read ACK 3 cycles after RDEN, write ACK 2 cycles after WREN.
    initial begin : ctrl_model
        int          cd;
        logic [31:0] rd;
        logic        stray_seen;
        cd = 0; rd = 32'h0; stray_seen = 1'b0;
        i_ACK = 1'b0; i_RDATA = 32'hBAD0BAD0;
        forever begin
            @(posedge clk); #1;
            i_ACK   = 1'b0;
            i_RDATA = 32'hBAD0BAD0;
            if (!i_reset) begin
                cd = 0;
            end else begin
                if (stray_tgl != stray_seen) begin
                    stray_seen = stray_tgl;
                    i_ACK = 1'b1;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        i_ACK   = 1'b1;
                        i_RDATA = rd;
                    end
                end
                if (!ctr_mute) begin
                    if (o_RDEN) begin
                        cd = 3; rd = pat(o_ADDR);
                    end else if (o_WREN) begin
                        cd = 2; rd = 32'h0BADF00D;
                    end
                end
            end
        end
    end

    task automatic take(input int p, input logic [31:0] rd, input logic er, input logic ak);
        exp_t e;
        logic [31:0] want;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            chk(p == 0 ? "ack0_unexpected" : "ack1_unexpected", 64'(ak), 64'd0);
            return;
        end
        if (p == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        want = e.wr ? last_rd[p] : e.rdata;
        chk(p == 0 ? "m0_rdata" : "m1_rdata", 64'(rd), 64'(want));
        chk(p == 0 ? "m0_err" : "m1_err", 64'(er), 64'(e.err));
        last_rd[p] = want;
        ack_log.push_back(p);
    endtask

    // Scoreboard consumer: pops an expectation whenever a port acks.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                last_rd[0] = 32'h0;
                last_rd[1] = 32'h0;
            end else begin
                chk("dual_ack", 64'(o_m0_ack & o_m1_ack), 64'd0);
                if (o_m0_ack) take(0, o_m0_rdata, o_m0_err, o_m0_ack);
                if (o_m1_ack) take(1, o_m1_rdata, o_m1_err, o_m1_ack);
            end
        end
    end

    // Single transaction from IDLE; starts and ends on a falling edge.
    task automatic run_txn(input vec_t v, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   k;
        logic got;
        e.wr = v.wren; e.rdata = exp_rd; e.err = exp_err;
        push_exp(v.port, e);
        set_payload(v.port, 1'b1, v.wren, v.addr, v.wdata, v.bmask);
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("t1_rden", 64'(o_RDEN), 64'(!v.wren));
                chk("t1_wren", 64'(o_WREN), 64'(v.wren));
                chk("t1_addr", 64'(o_ADDR), 64'(v.addr));
                chk("t1_wdata", 64'(o_WDATA), 64'(v.wdata));
                chk("t1_bmask", 64'(o_BMASK), 64'(v.bmask));
                chk("t1_grant", 64'(o_grant), 64'(gnt(v.port)));
                chk("t1_busy", 64'(o_busy), 64'd1);
            end
            if (k == 2) begin
                chk("t2_strobes", 64'({o_WREN, o_RDEN}), 64'd0);
                if (v.scramble)
                    set_payload(v.port, 1'b1, v.wren, ~v.addr, ~v.wdata, ~v.bmask);
            end
            if (ack_of(v.port)) begin
                got = 1'b1;
                chk("ack_latency", 64'(k), 64'(v.lat));
                chk("resp_addr", 64'(o_ADDR), 64'(v.addr));
                chk("resp_wdata", 64'(o_WDATA), 64'(v.wdata));
                chk("resp_grant", 64'(o_grant), 64'(gnt(v.port)));
                set_payload(v.port, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
            end
        end
        if (!got) chk("ack_wait", 64'(ack_of(v.port)), 64'd1);
        @(negedge clk);
        chk("idle_after", 64'({o_busy, o_grant}), 64'd0);
    endtask

    // Back-to-back reads with req held high across acks.
    task automatic drive_port(input int p, input int n, input logic [17:0] base);
        exp_t        e;
        logic [17:0] a;
        int          w;
        for (int k = 0; k < n; k++) begin
            a = base + 18'(k);
            e.wr = 1'b0; e.rdata = pat(a); e.err = 1'b0;
            push_exp(p, e);
            set_payload(p, 1'b1, 1'b0, a, 32'h0, 4'hF);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!ack_of(p) && w < 100);
            if (!ack_of(p)) chk("stream_ack_wait", 64'(ack_of(p)), 64'd1);
        end
        set_payload(p, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({o_WREN, o_RDEN, o_busy, o_grant, o_m0_ack, o_m1_ack,
                                 o_m0_err, o_m1_err}), 64'd0);
        chk({tag, "_rdata0"}, 64'(o_m0_rdata), 64'd0);
        chk({tag, "_rdata1"}, 64'(o_m1_rdata), 64'd0);
        chk({tag, "_addr"}, 64'(o_ADDR), 64'd0);
        chk({tag, "_wdata"}, 64'(o_WDATA), 64'd0);
        chk({tag, "_bmask"}, 64'(o_BMASK), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        vec_t vecs[7];
        vec_t tv;
        int   base;

        i_reset = 1'b0;
        set_payload(0, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
        set_payload(1, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        i_reset = 1'b1;

        //          port wren addr       wdata         bmask scr lat exp_rdata
        vecs[0] = '{0, 1'b0, 18'h00010, 32'h11111111, 4'hF, 1'b0, 5, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 18'h00100, 32'hCAFEF00D, 4'hF, 1'b0, 4, 32'h0};
        vecs[2] = '{1, 1'b0, 18'h00100, 32'h0,        4'hF, 1'b0, 5, pat(18'h00100)};
        vecs[3] = '{0, 1'b1, 18'h3FFFF, 32'h12345678, 4'h3, 1'b0, 4, 32'h0};
        vecs[4] = '{0, 1'b0, 18'h2ABCD, 32'h0,        4'hF, 1'b1, 5, pat(18'h2ABCD)};
        vecs[5] = '{1, 1'b0, 18'h3FFFF, 32'h0,        4'hF, 1'b0, 5, pat(18'h3FFFF)};
        vecs[6] = '{0, 1'b0, 18'h00000, 32'h0,        4'hF, 1'b0, 5, pat(18'h00000)};
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], vecs[i].exp_rdata, 1'b0);
        end

        // Controller never answers: abort after 16 WAIT cycles with err and zero data.
        ctr_mute = 1'b1;
        tv = '{0, 1'b0, 18'h00777, 32'h0, 4'hF, 1'b0, 18, 32'h0};
        run_txn(tv, 32'h0, 1'b1);
        ctr_mute = 1'b0;
        stray_tgl = ~stray_tgl;          // ACK lands two cycles after RESP
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stray_ack", 64'({o_m0_ack, o_m1_ack, o_busy}), 64'd0);
        end

        // Both ports stream reads from reset: owners must alternate starting with port 0.
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        base = ack_log.size();
        fork
            drive_port(0, 3, 18'h01000);
            drive_port(1, 3, 18'h02000);
        join
        @(negedge clk);
        chk("alt_count", 64'(ack_log.size() - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < ack_log.size()) chk("alt_order", 64'(ack_log[base + i]), 64'(i % 2));
        end

        // Reset lands during WAIT of a port-1 read; port 0 is pending.
        set_payload(1, 1'b1, 1'b0, 18'h00155, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        chk("wait_busy", 64'({o_busy, o_grant}), 64'b110);
        set_payload(1, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
        set_payload(0, 1'b1, 1'b0, 18'h0AAAA, 32'h0, 4'hF);
        i_reset = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        i_reset = 1'b1;
        base = ack_log.size();
        fork
            drive_port(0, 1, 18'h0AAAA);
            drive_port(1, 1, 18'h01555);
        join
        @(negedge clk);
        chk("rst_count", 64'(ack_log.size() - base), 64'd2);
        if (base < ack_log.size()) chk("rst_first", 64'(ack_log[base]), 64'd0);

        repeat (3) @(negedge clk);
        chk("sb0_left", 64'(sb0.size()), 64'd0);
        chk("sb1_left", 64'(sb1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
